chacha_block_scheduler: RTL and testbench

//  Sequences the single ChaCha20 block-function core and shares it between two requesters.

---
 rtl/chacha_block_scheduler.sv | 153 +++++++++++++++
 tb/tb_chacha_block_scheduler.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_block_scheduler.sv
// Shares one ChaCha20 block core between a one-shot Poly1305 key request and
// multi-block encryption keystream bursts, driving core start/counter and done strobes.
module chacha_block_scheduler #(
  parameter logic [31:0] ENC_CTR_INIT   = 32'd1,
  parameter int          NBLK_W         = 16,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              poly_req,
  output logic              poly_ack,
  output logic              poly_done,
  input  logic              enc_req,
  input  logic [NBLK_W-1:0] enc_nblocks,
  output logic              enc_ack,
  output logic              enc_blk_done,
  output logic              enc_last,
  output logic              core_start,
  output logic [31:0]       core_counter,
  input  logic              core_done,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NBLK_W-1:0] ONE_BLK = NBLK_W'(1);

  logic [2:0]        state;
  logic              job_poly;   // current job is the poly-key block
  logic              job_new;    // enc job still has to latch its burst length
  logic [NBLK_W-1:0] remaining;
  logic [31:0]       enc_ctr;
  logic [TO_W-1:0]   wait_cnt;

  // An open burst keeps the scheduler busy between its blocks, but an error
  // freezes everything and reports idle.
  assign busy = (state != S_ERR) && ((state != S_IDLE) || (remaining != '0));
  assign err  = (state == S_ERR);

  // NOTE: all sequential state uses non-blocking assignment so every branch
  // below reads the values from the start of the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      job_poly     <= 1'b0;
      job_new      <= 1'b0;
      remaining    <= '0;
      enc_ctr      <= ENC_CTR_INIT;
      wait_cnt     <= '0;
      poly_ack     <= 1'b0;
      poly_done    <= 1'b0;
      enc_ack      <= 1'b0;
      enc_blk_done <= 1'b0;
      enc_last     <= 1'b0;
      core_start   <= 1'b0;
      core_counter <= '0;
    end else begin
      // NOTE: strobes default low here, so each one is exactly one cycle wide
      // and no branch has to remember to clear it.
      poly_ack     <= 1'b0;
      poly_done    <= 1'b0;
      enc_ack      <= 1'b0;
      enc_blk_done <= 1'b0;
      enc_last     <= 1'b0;
      core_start   <= 1'b0;

      case (state)
        S_IDLE: begin
          // Poly wins every block boundary; an open burst beats a new enc request.
          if (poly_req) begin
            job_poly <= 1'b1;
            job_new  <= 1'b1;
            poly_ack <= 1'b1;
            state    <= S_ISSUE;
          end else if (remaining != '0) begin
            job_poly <= 1'b0;
            job_new  <= 1'b0;
            state    <= S_ISSUE;
          end else if (enc_req) begin
            job_poly <= 1'b0;
            job_new  <= 1'b1;
            enc_ack  <= 1'b1;
            state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wait_cnt <= '0;
          if (job_poly) begin
            core_counter <= 32'd0;
            core_start   <= 1'b1;
            state        <= S_WAIT;
          end else if (job_new) begin
            // Burst length is taken in the cycle enc_ack is visible.
            remaining <= enc_nblocks;
            enc_ctr   <= ENC_CTR_INIT;
            if (enc_nblocks == '0) begin
              enc_blk_done <= 1'b1;
              enc_last     <= 1'b1;
              state        <= S_DONE;
            end else begin
              core_counter <= ENC_CTR_INIT;
              core_start   <= 1'b1;
              state        <= S_WAIT;
            end
          end else begin
            core_counter <= enc_ctr;
            core_start   <= 1'b1;
            state        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (core_done) begin
            state <= S_DONE;
            if (job_poly) begin
              poly_done <= 1'b1;
            end else begin
              enc_blk_done <= 1'b1;
              enc_last     <= (remaining == ONE_BLK);
              remaining    <= remaining - ONE_BLK;
              enc_ctr      <= enc_ctr + 32'd1;
            end
          end else if (wait_cnt == TO_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // A counter that rolled over to 0 with blocks still owed would reuse a nonce block.
          if (!job_poly && (remaining != '0) && (enc_ctr == 32'd0)) begin
            state <= S_ERR;
          end else begin
            state <= S_IDLE;
          end
        end

        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_scheduler.sv
// Self-checking bench for chacha_block_scheduler: randomized core latencies and
// burst shapes checked against expected counter and event sequences.
module tb_chacha_block_scheduler;

  typedef logic [31:0] word_t;

  localparam word_t ENC_INIT  = 32'd1;
  localparam word_t WRAP_INIT = 32'hFFFF_FFFE;

  // event codes recorded by the monitor
  localparam word_t EV_POLY_DONE = 32'd0;
  localparam word_t EV_ENC_BLK   = 32'd1;
  localparam word_t EV_ENC_LAST  = 32'd2;
  localparam word_t EV_ENC_ACK   = 32'd3;
  localparam word_t EV_POLY_ACK  = 32'd4;
  localparam word_t EV_STRAY     = 32'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poly_req = 1'b0, enc_req = 1'b0, core_done = 1'b0;
  logic [15:0] enc_nblocks = '0;
  logic        poly_ack, poly_done, enc_ack, enc_blk_done, enc_last, core_start, busy, err;
  logic [31:0] core_counter;

  logic        w_poly_req = 1'b0, w_enc_req = 1'b0, w_core_done = 1'b0;
  logic [15:0] w_enc_nblocks = '0;
  logic        w_poly_ack, w_poly_done, w_enc_ack, w_enc_blk_done, w_enc_last, w_core_start, w_busy, w_err;
  logic [31:0] w_core_counter;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    lat_min = 1, lat_max = 30;
  bit    hold_done = 1'b0;
  bit    abort_resp = 1'b0;
  word_t start_q[$];
  word_t ev_q[$];

  chacha_block_scheduler #(.ENC_CTR_INIT(ENC_INIT), .NBLK_W(16), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .poly_req(poly_req), .poly_ack(poly_ack), .poly_done(poly_done),
    .enc_req(enc_req), .enc_nblocks(enc_nblocks), .enc_ack(enc_ack),
    .enc_blk_done(enc_blk_done), .enc_last(enc_last),
    .core_start(core_start), .core_counter(core_counter), .core_done(core_done),
    .busy(busy), .err(err)
  );

  chacha_block_scheduler #(.ENC_CTR_INIT(WRAP_INIT), .NBLK_W(16), .TIMEOUT_CYCLES(64)) dut_w (
    .clk(clk), .rst(rst),
    .poly_req(w_poly_req), .poly_ack(w_poly_ack), .poly_done(w_poly_done),
    .enc_req(w_enc_req), .enc_nblocks(w_enc_nblocks), .enc_ack(w_enc_ack),
    .enc_blk_done(w_enc_blk_done), .enc_last(w_enc_last),
    .core_start(w_core_start), .core_counter(w_core_counter), .core_done(w_core_done),
    .busy(w_busy), .err(w_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int q_diff(input word_t a[$], input word_t b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic string fmt_q(input word_t q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0h ", q[i])};
    return s;
  endfunction

  // Event monitor: records every start counter and every strobe in order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (core_start) start_q.push_back(core_counter);
        if (poly_ack) ev_q.push_back(EV_POLY_ACK);
        if (enc_ack) ev_q.push_back(EV_ENC_ACK);
        if (poly_done) ev_q.push_back(EV_POLY_DONE);
        if (enc_blk_done) ev_q.push_back(enc_last ? EV_ENC_LAST : EV_ENC_BLK);
        if (enc_last && !enc_blk_done) ev_q.push_back(EV_STRAY);
      end
    end
  end

  // Requesters hold their level until the ack is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (poly_ack) poly_req = 1'b0;
      if (enc_ack) enc_req = 1'b0;
    end
  end

  // Core model: answers each start after a random latency and checks the counter held still.
  initial begin
    word_t c;
    int    d;
    forever begin
      @(negedge clk);
      if (core_start && !rst && !hold_done) begin
        c = core_counter;
        abort_resp = 1'b0;
        d = $urandom_range(lat_min, lat_max);
        repeat (d) @(negedge clk);
        if (!abort_resp) begin
          total++;
          if (core_counter !== c) begin
            bad++;
            $display("FAIL counter_stable: got %h want %h", core_counter, c);
          end
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_quiet(input int max_cyc, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && !poly_req && !enc_req) quiet++; else quiet = 0;
      if (quiet >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({poly_ack, poly_done, enc_ack, enc_blk_done, enc_last, core_start, busy, err} !== 8'd0 ||
        core_counter !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got strobes=%b ctr=%h want 0", 
               {poly_ack, poly_done, enc_ack, enc_blk_done, enc_last, core_start, busy, err}, core_counter);
    end
    total++;
    if ({w_poly_ack, w_poly_done, w_enc_ack, w_enc_blk_done, w_enc_last, w_core_start, w_busy, w_err} !== 8'd0 ||
        w_core_counter !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs_w: got ctr=%h busy=%b err=%b want 0", w_core_counter, w_busy, w_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || err !== 1'b0 || core_start !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b err=%b start=%b want 0", busy, err, core_start);
    end
  endtask

  task automatic test_poly_only();
    int  st, dc;
    bit  seen = 1'b0, ok;
    word_t es[$], ee[$];
    start_q.delete(); ev_q.delete();
    lat_min = 20; lat_max = 20;
    @(negedge clk);
    poly_req = 1'b1;
    @(negedge clk);
    total++;
    if (poly_ack !== 1'b1) begin
      bad++;
      $display("FAIL poly_ack_latency: got %b want 1", poly_ack);
    end
    @(negedge clk);
    st = cyc;
    total++;
    if (core_start !== 1'b1 || core_counter !== 32'd0) begin
      bad++;
      $display("FAIL poly_start: got start=%b ctr=%h want 1/0", core_start, core_counter);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (poly_done) begin
        seen = 1'b1;
        dc = cyc;
        break;
      end
    end
    total++;
    if (!seen || dc != st + 21) begin
      bad++;
      $display("FAIL poly_done_latency: got seen=%b at +%0d want +21", seen, dc - st);
    end
    wait_quiet(200, ok);
    es = '{32'd0};
    ee = '{EV_POLY_ACK, EV_POLY_DONE};
    total++;
    if (!ok || q_diff(start_q, es) != -1 || q_diff(ev_q, ee) != -1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL poly_only: got starts {%s} events {%s} busy=%b want {%s} {%s}",
               fmt_q(start_q), fmt_q(ev_q), busy, fmt_q(es), fmt_q(ee));
    end
    lat_min = 1; lat_max = 30;
  endtask

  // One enc burst of n blocks; poly_req is raised while block poly_after is in the core.
  task automatic test_burst(input string name, input int n, input int poly_after);
    int    ns = 0, quiet = 0;
    bit    ok = 1'b0;
    word_t es[$], ee[$];
    start_q.delete(); ev_q.delete();
    ee.push_back(EV_ENC_ACK);
    for (int i = 0; i < n; i++) begin
      es.push_back(ENC_INIT + word_t'(i));
      ee.push_back((i == n - 1) ? EV_ENC_LAST : EV_ENC_BLK);
      if (i + 1 == poly_after) begin
        es.push_back(32'd0);
        ee.push_back(EV_POLY_ACK);
        ee.push_back(EV_POLY_DONE);
      end
    end
    @(negedge clk);
    enc_nblocks = 16'(n);
    enc_req = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (core_start) begin
        ns++;
        if (ns == poly_after) poly_req = 1'b1;
      end
      if (!busy && !poly_req && !enc_req) quiet++; else quiet = 0;
      if (quiet >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: got still busy want idle", name);
    end
    total++;
    if (q_diff(start_q, es) != -1) begin
      bad++;
      $display("FAIL %s_counters: got {%s} want {%s}", name, fmt_q(start_q), fmt_q(es));
    end
    total++;
    if (q_diff(ev_q, ee) != -1) begin
      bad++;
      $display("FAIL %s_events: got {%s} want {%s}", name, fmt_q(ev_q), fmt_q(ee));
    end
  endtask

  task automatic test_random_bursts();
    int n, pa;
    for (int k = 0; k < 5; k++) begin
      n  = $urandom_range(1, 6);
      pa = $urandom_range(0, n);
      test_burst($sformatf("random%0d", k), n, pa);
    end
  endtask

  task automatic test_simultaneous();
    bit    ok;
    word_t es[$], ee[$];
    start_q.delete(); ev_q.delete();
    @(negedge clk);
    enc_nblocks = 16'd2;
    poly_req = 1'b1;
    enc_req = 1'b1;
    wait_quiet(2000, ok);
    es = '{32'd0, 32'd1, 32'd2};
    ee = '{EV_POLY_ACK, EV_POLY_DONE, EV_ENC_ACK, EV_ENC_BLK, EV_ENC_LAST};
    total++;
    if (!ok || q_diff(start_q, es) != -1 || q_diff(ev_q, ee) != -1) begin
      bad++;
      $display("FAIL simultaneous: got starts {%s} events {%s} want {%s} {%s}",
               fmt_q(start_q), fmt_q(ev_q), fmt_q(es), fmt_q(ee));
    end
  endtask

  task automatic test_zero_blocks();
    bit    seen = 1'b0, ok;
    word_t ee[$];
    start_q.delete(); ev_q.delete();
    @(negedge clk);
    enc_nblocks = 16'd0;
    enc_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (enc_ack) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    total++;
    if (!seen || enc_blk_done !== 1'b1 || enc_last !== 1'b1) begin
      bad++;
      $display("FAIL zero_blocks_done: got ack=%b blk_done=%b last=%b want 1/1/1", seen, enc_blk_done, enc_last);
    end
    wait_quiet(100, ok);
    // a core_done with nothing in flight must be ignored
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    ee = '{EV_ENC_ACK, EV_ENC_LAST};
    total++;
    if (!ok || start_q.size() != 0 || q_diff(ev_q, ee) != -1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_blocks: got starts=%0d events {%s} busy=%b want 0 {%s} 0",
               start_q.size(), fmt_q(ev_q), busy, fmt_q(ee));
    end
  endtask

  task automatic test_back_to_back();
    int    ns = 0;
    bit    ok;
    word_t es[$], ee[$];
    start_q.delete(); ev_q.delete();
    @(negedge clk);
    enc_nblocks = 16'd3;
    enc_req = 1'b1;
    for (int i = 0; i < 200 && ns == 0; i++) begin
      @(negedge clk);
      if (core_start) ns++;
    end
    @(negedge clk);
    enc_nblocks = 16'd2;
    enc_req = 1'b1;
    wait_quiet(3000, ok);
    es = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd2};
    ee = '{EV_ENC_ACK, EV_ENC_BLK, EV_ENC_BLK, EV_ENC_LAST, EV_ENC_ACK, EV_ENC_BLK, EV_ENC_LAST};
    total++;
    if (!ok || q_diff(start_q, es) != -1 || q_diff(ev_q, ee) != -1) begin
      bad++;
      $display("FAIL back_to_back: got starts {%s} events {%s} want {%s} {%s}",
               fmt_q(start_q), fmt_q(ev_q), fmt_q(es), fmt_q(ee));
    end
  endtask

  task automatic test_reset_mid_burst();
    int ns = 0;
    lat_min = 10; lat_max = 10;
    @(negedge clk);
    enc_nblocks = 16'd5;
    enc_req = 1'b1;
    for (int i = 0; i < 300 && ns < 2; i++) begin
      @(negedge clk);
      if (core_start) ns++;
    end
    @(negedge clk);
    rst = 1'b1;
    abort_resp = 1'b1;
    @(negedge clk);
    total++;
    if (ns != 2 || {poly_ack, poly_done, enc_ack, enc_blk_done, enc_last, core_start, busy, err} !== 8'd0 ||
        core_counter !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_burst: got starts=%0d strobes=%b ctr=%h want 2/0/0", ns,
               {poly_ack, poly_done, enc_ack, enc_blk_done, enc_last, core_start, busy, err}, core_counter);
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    lat_min = 1; lat_max = 30;
    test_burst("after_reset", 2, 0);
  endtask

  task automatic test_wrap();
    word_t wq[$], es[$];
    int    cd = 0;
    bit    last_seen = 1'b0;
    @(negedge clk);
    w_enc_nblocks = 16'd3;
    w_enc_req = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (w_enc_ack) w_enc_req = 1'b0;
      if (w_enc_last) last_seen = 1'b1;
      w_core_done = 1'b0;
      if (w_core_start) begin
        wq.push_back(w_core_counter);
        cd = 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) w_core_done = 1'b1;
      end
    end
    w_core_done = 1'b0;
    es = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
    total++;
    if (q_diff(wq, es) != -1) begin
      bad++;
      $display("FAIL wrap_counters: got {%s} want {%s}", fmt_q(wq), fmt_q(es));
    end
    total++;
    if (w_err !== 1'b1 || w_busy !== 1'b0 || last_seen) begin
      bad++;
      $display("FAIL wrap_err: got err=%b busy=%b last_seen=%b want 1/0/0", w_err, w_busy, last_seen);
    end
  endtask

  task automatic test_timeout_and_recover();
    bit    seen = 1'b0, ok;
    word_t es[$], ee[$];
    start_q.delete(); ev_q.delete();
    hold_done = 1'b1;
    @(negedge clk);
    poly_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_start) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (40) @(negedge clk);
    total++;
    if (!seen || err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got start=%b err=%b busy=%b want 1/0/1", seen, err, busy);
    end
    repeat (60) @(negedge clk);
    #1;
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || start_q.size() != 1) begin
      bad++;
      $display("FAIL timeout_err: got err=%b busy=%b starts=%0d want 1/0/1", err, busy, start_q.size());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({poly_ack, poly_done, enc_ack, enc_blk_done, enc_last, core_start, busy, err} !== 8'd0 ||
        core_counter !== 32'd0) begin
      bad++;
      $display("FAIL timeout_reset: got strobes=%b ctr=%h want 0",
               {poly_ack, poly_done, enc_ack, enc_blk_done, enc_last, core_start, busy, err}, core_counter);
    end
    rst = 1'b0;
    hold_done = 1'b0;
    start_q.delete(); ev_q.delete();
    @(negedge clk);
    poly_req = 1'b1;
    wait_quiet(300, ok);
    es = '{32'd0};
    ee = '{EV_POLY_ACK, EV_POLY_DONE};
    total++;
    if (!ok || q_diff(start_q, es) != -1 || q_diff(ev_q, ee) != -1 || err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_recover: got starts {%s} events {%s} err=%b want {%s} {%s} 0",
               fmt_q(start_q), fmt_q(ev_q), err, fmt_q(es), fmt_q(ee));
    end
  endtask

  initial begin
    test_reset();
    test_poly_only();
    test_burst("enc_burst", 3, 0);
    test_burst("poly_insert", 4, 2);
    test_random_bursts();
    test_simultaneous();
    test_zero_blocks();
    test_back_to_back();
    test_reset_mid_burst();
    test_wrap();
    test_timeout_and_recover();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
